// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - round-robin owner of the 4-LED bank with idle chaser
//
// Shares the active-low LED bank among three requesters. When nobody owns the
// bank, a right-rotating chaser is shown. Each grant holds the bank for a fixed
// dwell time (optionally blinking) and is followed by an all-off gap.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   req    in   [2:0] level-sensitive requests, one per requester
//   pat0-2 in   [3:0] active-high LED pattern per requester
//   blink  in   [2:0] per-requester blink enable
//   gnt    out  [2:0] one-hot grant, zero when nobody owns the bank
//   busy   out  high while granting or in the gap
//   L      out  [3:0] active-low LED drive, registered
module led_share_arbiter #(
   parameter int TICK_DIV    = 50000,
   parameter int DWELL_TICKS = 500,
   parameter int BLINK_TICKS = 125,
   parameter int CHASE_TICKS = 1000,
   parameter int GAP_TICKS   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [3:0] pat0,
   input  logic [3:0] pat1,
   input  logic [3:0] pat2,
   input  logic [2:0] blink,
   output logic [2:0] gnt,
   output logic       busy,
   output logic [3:0] L
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
   localparam logic [31:0] DWELL_LAST = 32'(DWELL_TICKS - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_TICKS - 1);
   localparam logic [31:0] CHASE_LAST = 32'(CHASE_TICKS - 1);
   localparam logic [31:0] GAP_LAST   = 32'(GAP_TICKS - 1);

   logic [1:0]  state_q,  state_d;
   logic [31:0] presc_q,  presc_d;
   logic [31:0] tcnt_q,   tcnt_d;
   logic [31:0] sub_q,    sub_d;
   logic [3:0]  chaser_q, chaser_d;
   logic [1:0]  last_q,   last_d;
   logic [1:0]  owner_q,  owner_d;
   logic        phase_q,  phase_d;
   logic [2:0]  gnt_q,    gnt_d;
   logic        busy_q,   busy_d;
   logic [3:0]  l_q,      l_d;

   logic        tick;
   logic        sub_wrap;
   logic [31:0] sub_last;
   logic        entry;
   logic [1:0]  win_idx;
   logic        own_req;
   logic        own_blink;
   logic [3:0]  sel_pat;
   logic        sel_blink;

   // Round-robin search starting just after the last winner.
   always_comb begin
      win_idx = 2'd0;
      case (last_q)
         2'd0: begin
            if      (req[1]) win_idx = 2'd1;
            else if (req[2]) win_idx = 2'd2;
            else             win_idx = 2'd0;
         end
         2'd1: begin
            if      (req[2]) win_idx = 2'd2;
            else if (req[0]) win_idx = 2'd0;
            else             win_idx = 2'd1;
         end
         default: begin
            if      (req[0]) win_idx = 2'd0;
            else if (req[1]) win_idx = 2'd1;
            else             win_idx = 2'd2;
         end
      endcase
   end

   always_comb begin
      own_req   = req[2];
      own_blink = blink[2];
      case (owner_q)
         2'd0:    begin own_req = req[0]; own_blink = blink[0]; end
         2'd1:    begin own_req = req[1]; own_blink = blink[1]; end
         default: begin own_req = req[2]; own_blink = blink[2]; end
      endcase
   end

   always_comb begin
      tick = (presc_q == TICK_LAST);
      // One sub-counter serves both the chaser period (IDLE) and the blink
      // half-period (GRANT); it marks every Nth tick since state entry.
      sub_last = (state_q == S_IDLE) ? CHASE_LAST : BLINK_LAST;
      sub_wrap = tick && (sub_q == sub_last);

      state_d  = state_q;
      chaser_d = chaser_q;
      last_d   = last_q;
      owner_d  = owner_q;
      phase_d  = phase_q;

      case (state_q)
         S_IDLE: begin
            if (sub_wrap) begin
               chaser_d = {chaser_q[0], chaser_q[3:1]};
            end
            if (req != 3'b000) begin
               state_d = S_GRANT;
               owner_d = win_idx;
               last_d  = win_idx;
               phase_d = 1'b1;
            end
         end
         S_GRANT: begin
            if (own_blink && sub_wrap) begin
               phase_d = ~phase_q;
            end
            // Early release and dwell completion both lead to GAP.
            if (!own_req || (tick && (tcnt_q == DWELL_LAST))) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (tick && (tcnt_q == GAP_LAST)) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The FSM never stays in a state through a self-transition, so any
      // change of state is a state entry that restarts all timing.
      entry = (state_d != state_q);
      if (entry) begin
         presc_d = 32'd0;
         tcnt_d  = 32'd0;
         sub_d   = 32'd0;
      end else begin
         presc_d = tick ? 32'd0 : presc_q + 32'd1;
         tcnt_d  = tcnt_q + {31'd0, tick};
         if (sub_wrap) begin
            sub_d = 32'd0;
         end else if (tick) begin
            sub_d = sub_q + 32'd1;
         end else begin
            sub_d = sub_q;
         end
      end
   end

   // Outputs are computed from the next state so they change on the same
   // edge as the state they describe.
   always_comb begin
      sel_pat   = pat2;
      sel_blink = blink[2];
      case (owner_d)
         2'd0:    begin sel_pat = pat0; sel_blink = blink[0]; end
         2'd1:    begin sel_pat = pat1; sel_blink = blink[1]; end
         default: begin sel_pat = pat2; sel_blink = blink[2]; end
      endcase

      busy_d = (state_d != S_IDLE);
      gnt_d  = (state_d == S_GRANT) ? (3'b001 << owner_d) : 3'b000;

      case (state_d)
         S_IDLE:  l_d = ~chaser_d;
         S_GRANT: l_d = (phase_d || !sel_blink) ? ~sel_pat : 4'b1111;
         default: l_d = 4'b1111;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         presc_q  <= 32'd0;
         tcnt_q   <= 32'd0;
         sub_q    <= 32'd0;
         chaser_q <= 4'b1000;
         last_q   <= 2'd2;
         owner_q  <= 2'd0;
         phase_q  <= 1'b1;
         gnt_q    <= 3'b000;
         busy_q   <= 1'b0;
         l_q      <= 4'b0111;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         tcnt_q   <= tcnt_d;
         sub_q    <= sub_d;
         chaser_q <= chaser_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         phase_q  <= phase_d;
         gnt_q    <= gnt_d;
         busy_q   <= busy_d;
         l_q      <= l_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign L    = l_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - self-checking bench for led_share_arbiter
module tb_led_share_arbiter;

   localparam int TD = 4;
   localparam int DW = 3;
   localparam int BT = 1;
   localparam int CT = 2;
   localparam int GT = 1;

   logic       clk;
   logic       rst;
   logic [2:0] req;
   logic [3:0] pat0;
   logic [3:0] pat1;
   logic [3:0] pat2;
   logic [2:0] blink;
   logic [2:0] gnt;
   logic       busy;
   logic [3:0] L;

   int n_checks = 0;
   int n_err    = 0;
   logic cmp_en = 1'b0;

   led_share_arbiter #(
      .TICK_DIV    (TD),
      .DWELL_TICKS (DW),
      .BLINK_TICKS (BT),
      .CHASE_TICKS (CT),
      .GAP_TICKS   (GT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .pat0  (pat0),
      .pat1  (pat1),
      .pat2  (pat2),
      .blink (blink),
      .gnt   (gnt),
      .busy  (busy),
      .L     (L)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: tracks cycles spent in the current state and derives
   // ticks, chaser steps, blink toggles and exits from cycle arithmetic.
   int         m_st   = 0;      // 0 idle, 1 grant, 2 gap
   int         m_n    = 0;      // edges since entering the current state
   logic [3:0] m_ch   = 4'b1000;
   int         m_last = 2;
   int         m_own  = 0;
   logic       m_ph   = 1'b1;
   logic [2:0] m_gnt  = 3'b000;
   logic       m_busy = 1'b0;
   logic [3:0] m_L    = 4'b0111;

   function automatic logic [3:0] pat_of(input int i);
      if (i == 0) return pat0;
      if (i == 1) return pat1;
      return pat2;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_st = 0; m_n = 0; m_ch = 4'b1000; m_last = 2; m_own = 0; m_ph = 1'b1;
         m_gnt = 3'b000; m_busy = 1'b0; m_L = 4'b0111;
      end else begin
         int n1;
         n1 = m_n + 1;
         if (m_st == 0) begin
            if (n1 % (TD * CT) == 0) m_ch = {m_ch[0], m_ch[3:1]};
            if (req != 3'b000) begin
               for (int k = 1; k <= 3; k++) begin
                  int idx;
                  idx = (m_last + k) % 3;
                  if (req[idx] && m_st == 0) begin
                     m_st = 1; m_own = idx;
                  end
               end
               m_last = m_own; m_ph = 1'b1; m_n = 0;
            end else begin
               m_n = n1;
            end
         end else if (m_st == 1) begin
            if ((n1 % (TD * BT) == 0) && blink[m_own]) m_ph = ~m_ph;
            if (!req[m_own] || n1 == TD * DW) begin
               m_st = 2; m_n = 0;
            end else begin
               m_n = n1;
            end
         end else begin
            if (n1 == TD * GT) begin
               m_st = 0; m_n = 0;
            end else begin
               m_n = n1;
            end
         end
         m_gnt  = (m_st == 1) ? 3'(1 << m_own) : 3'b000;
         m_busy = (m_st != 0);
         if (m_st == 0)      m_L = ~m_ch;
         else if (m_st == 1) m_L = (m_ph || !blink[m_own]) ? ~pat_of(m_own) : 4'b1111;
         else                m_L = 4'b1111;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_gnt", 8'(gnt), 8'(m_gnt));
         chk("model_busy", 8'(busy), 8'(m_busy));
         chk("model_L", 8'(L), 8'(m_L));
         chk("onehot", 8'($countones(gnt) <= 1), 8'd1);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [3:0] chase_tab [5];

   initial begin
      chase_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
      rst = 1'b0; req = 3'b000; blink = 3'b000;
      pat0 = 4'b1010; pat1 = 4'b1111; pat2 = 4'b0110;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_gnt", 8'(gnt), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_L", 8'(L), 8'b0111);

      // Idle chaser
      rst = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         step();
         chk("chase_L", 8'(L), 8'(chase_tab[k / 8]));
      end

      // Single grant, gap, one idle cycle, re-grant
      req = 3'b001;
      for (int k = 0; k <= 17; k++) begin
         step();
         if (k < 12 || k == 17) begin
            chk("single_gnt", 8'(gnt), 8'b001);
            chk("single_L", 8'(L), 8'b0101);
         end else if (k < 16) begin
            chk("gap_gnt", 8'(gnt), 8'b000);
            chk("gap_L", 8'(L), 8'b1111);
            chk("gap_busy", 8'(busy), 8'd1);
         end else begin
            chk("idle_busy", 8'(busy), 8'd0);
            chk("idle_L", 8'(L), 8'b0111);
         end
      end

      // Early release five cycles into the grant
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("hold_gnt", 8'(gnt), 8'b001);
      end
      req = 3'b000;
      step();
      chk("early_gnt", 8'(gnt), 8'b000);
      chk("early_L", 8'(L), 8'b1111);
      chk("early_busy", 8'(busy), 8'd1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("early_gap_busy", 8'(busy), 8'd1);
      end
      step();
      chk("early_idle_busy", 8'(busy), 8'd0);
      chk("early_idle_L", 8'(L), 8'b0111);

      // Blink on requester 1
      req = 3'b010; blink = 3'b010;
      for (int k = 0; k <= 16; k++) begin
         step();
         if (k < 12) begin
            chk("blink_gnt", 8'(gnt), 8'b010);
            chk("blink_L", 8'(L), ((k / 4) % 2 == 0) ? 8'b0000 : 8'b1111);
         end else if (k < 16) begin
            chk("blink_gap_L", 8'(L), 8'b1111);
         end else begin
            chk("blink_idle_busy", 8'(busy), 8'd0);
         end
         if (k == 12) req = 3'b000;
      end

      // Async reset mid-grant, then round robin from requester 0
      blink = 3'b000; req = 3'b111;
      step();
      chk("pre_rst_gnt", 8'(gnt), 8'b100);
      chk("pre_rst_L", 8'(L), 8'b1001);
      repeat (2) step();
      #2 rst = 1'b0;
      #1;
      chk("async_gnt", 8'(gnt), 8'd0);
      chk("async_busy", 8'(busy), 8'd0);
      chk("async_L", 8'(L), 8'b0111);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k <= 51; k++) begin
         step();
         if (k == 0 || k == 11 || k == 51) chk("rr_gnt0", 8'(gnt), 8'b001);
         if (k == 0) chk("rr_L0", 8'(L), 8'b0101);
         if (k == 12) begin
            chk("rr_gap_gnt", 8'(gnt), 8'b000);
            chk("rr_gap_busy", 8'(busy), 8'd1);
         end
         if (k == 16) chk("rr_idle_busy", 8'(busy), 8'd0);
         if (k == 17) chk("rr_gnt1", 8'(gnt), 8'b010);
         if (k == 34) chk("rr_gnt2", 8'(gnt), 8'b100);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/led_share_arbiter.md
# led_share_arbiter

Round-robin owner of the 4-LED bank on the EPM240 core board. It shares the LEDs among three requesters and shows an idle right-rotating chaser when no requester holds the bank. Each grant holds the bank for a fixed dwell time, optionally blinking the owner's pattern, and is followed by an all-off gap. It sits between the application blocks and the board LED pins, driving the active-low L[3:0].

## Interface
- TICK_DIV, 50000: clocks per tick (1 ms at 50 MHz); must be at least 1.
- DWELL_TICKS, 500: ticks per grant; must be at least 1.
- BLINK_TICKS, 125: ticks per blink half-period; must be at least 1.
- CHASE_TICKS, 1000: ticks per idle chaser step; must be at least 1.
- GAP_TICKS, 50: ticks of all-off gap after each grant; must be at least 1.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- req  in  3  request, one bit per requester; level-sensitive.
- pat0, pat1, pat2  in  4 each  active-high pattern for each requester.
- blink  in  3  per-requester blink enable.
- gnt  out  3  one-hot grant; all zeros when no requester owns the bank.
- busy  out  1  high in GRANT and GAP.
- L  out  4  active-low LED drive, registered.

## Operation
- States:
  - IDLE: shows the chaser.
  - GRANT: shows the owner's pattern.
  - GAP: L = 4'b1111.
- Prescaler: 32-bit, counts 0..TICK_DIV-1. tick = (count == TICK_DIV-1).
  - Cleared to 0 on every state entry.
  - Free-runs within a state.
- Tick counter: 32-bit, cleared on every state entry, incremented on tick.
- Chaser register:
  - Reset value 4'b1000.
  - In IDLE it rotates right ({c[0],c[3:1]}) on each tick where ticks-in-state+1 is a multiple of CHASE_TICKS.
  - Holds its value outside IDLE and is not reset by grants.
  - L = ~chaser in IDLE.
- Arbitration (IDLE only):
  - If req != 0 at a clock edge, enter GRANT on that edge with gnt = the winner.
  - Winner is the first set bit searching from last+1, wrapping modulo 3.
  - The last pointer updates to the winner; its reset value is 2, so requester 0 wins first.
- GRANT:
  - Blink phase is set on entry.
  - If blink[i] = 1, the phase toggles on every BLINK_TICKS-th tick.
  - Display rule: L = ~pat_i when the phase is on or blink[i] = 0; otherwise L = 4'b1111.
  - pat and blink are sampled live; L is registered one cycle behind.
- GRANT exit, to GAP with gnt = 0 on that edge:
  - (a) req[i] low at an edge (early release); or
  - (b) the tick that completes DWELL_TICKS ticks.
  - If both occur together, (a) takes priority, with the same result.
- GAP: after GAP_TICKS ticks, enter IDLE. Arbitration then runs at the next edge, so a held request is re-granted one cycle later.
- A requester holding req through its dwell loses priority to any other pending requester.

## Timing
- Reset values, applied asynchronously while rst = 0:
  - gnt = 3'b000, busy = 0, L = 4'b0111.
  - State IDLE, chaser 4'b1000, last = 2.
  - All counters 0.
- Request to grant: gnt and busy assert on the first edge where req is sampled high in IDLE. L shows the pattern from that same edge.
- A full grant lasts exactly DWELL_TICKS*TICK_DIV cycles.
- GAP lasts exactly GAP_TICKS*TICK_DIV cycles, then one IDLE cycle minimum before the next grant.
- Early release: gnt drops on the edge that samples req[i] = 0.
- Reset mid-operation: outputs take their reset values immediately, and any grant is abandoned.
- gnt is never multi-hot and never changes owner without passing through GAP.

## Test plan
Bench parameters: TICK_DIV=4, DWELL_TICKS=3, BLINK_TICKS=1, CHASE_TICKS=2, GAP_TICKS=1.
- Idle chaser: release reset with req = 0 -> L = 0111 for 8 cycles, then 1011, then 1101 eight cycles later, wrapping to 0111 after 1110.
- Single grant: req = 001, pat0 = 1010, blink = 0 held -> gnt = 001 and L = 0101 for 12 cycles, then gnt = 000 and L = 1111 for 4 cycles, one IDLE cycle, then re-grant to 001.
- Round robin: req = 111 held -> grant order 001, 010, 100, 001, each separated by a 4-cycle gap.
- Blink: req = 010, pat1 = 1111, blink = 010 -> during GRANT, L alternates 0000 and 1111 every 4 cycles (0000, 1111, 0000).
- Early release: req0 dropped 5 cycles into its grant -> gnt = 000 on the sampling edge, L = 1111, GAP for 4 cycles.
- Async reset: assert rst low mid-grant, between clock edges -> gnt = 000, busy = 0, L = 0111 immediately. After release, requester 0 wins first.
